// File: rtl/vmem_arbiter_if.sv
// vmem_arbiter_if: display, CPU and RAM bus signals around the video memory arbiter.
interface vmem_arbiter_if #(parameter int AW = 16, parameter int DW = 8);
  logic          scan;
  logic          disp_req, disp_gnt, disp_valid;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_ack;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata;
  modport slave (
    input  scan, disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output disp_gnt, disp_valid, disp_data, cpu_gnt, cpu_ack, cpu_rdata, mem_addr, mem_we, mem_wdata
  );
  modport master (
    output scan, disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  disp_gnt, disp_valid, disp_data, cpu_gnt, cpu_ack, cpu_rdata, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vmem_arbiter.sv
// vmem_arbiter: shares the single-port video RAM between display fetch and CPU.
module vmem_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 8,
  parameter int STARVE_LIMIT = 8
) (
  input  logic           clk,
  input  logic           rst,
  vmem_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t        state;
  logic          owner;
  logic          cpu_win, disp_win;
  logic [3:0]    starve;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] rdata;
  always_comb begin
    cpu_win  = state != ACCESS && bus.cpu_req &&
               (!bus.disp_req || starve == 4'(STARVE_LIMIT) || !bus.scan);
    disp_win = state != ACCESS && bus.disp_req && !cpu_win;
    win_addr = cpu_win ? bus.cpu_addr : bus.disp_addr;
  end
  assign rdata         = bus.mem_rdata;
  assign bus.disp_data = rdata;
  assign bus.cpu_rdata = rdata;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state          <= IDLE;
      owner          <= 1'b0;
      starve         <= 4'd0;
      bus.mem_addr   <= '0;
      bus.mem_we     <= 1'b0;
      bus.mem_wdata  <= '0;
      bus.disp_gnt   <= 1'b0;
      bus.cpu_gnt    <= 1'b0;
      bus.disp_valid <= 1'b0;
      bus.cpu_ack    <= 1'b0;
    end else begin
      state          <= (cpu_win || disp_win) ? ACCESS : state == ACCESS ? RESP : IDLE;
      owner          <= (cpu_win || disp_win) ? cpu_win : owner;
      bus.disp_gnt   <= disp_win;
      bus.cpu_gnt    <= cpu_win;
      bus.mem_we     <= cpu_win && bus.cpu_we;
      bus.mem_addr   <= (cpu_win || disp_win) ? win_addr : bus.mem_addr;
      bus.mem_wdata  <= cpu_win ? bus.cpu_wdata : bus.mem_wdata;
      bus.disp_valid <= state == ACCESS && !owner;
      bus.cpu_ack    <= state == ACCESS && owner;
      // CPU is only starved by display wins it actually lost while asking
      starve         <= cpu_win ? 4'd0 :
                        (disp_win && bus.cpu_req && starve != 4'(STARVE_LIMIT)) ? starve + 4'd1 : starve;
    end
endmodule

// File: tb/tb_vmem_arbiter.sv
// tb_vmem_arbiter: directed and random checks of vmem_arbiter against a slot-level model.
module tb_vmem_arbiter;
  localparam int AW = 16, DW = 8, SL = 8;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  vmem_arbiter_if #(.AW(AW), .DW(DW)) bus();
  vmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(SL)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [DW-1:0] ram [256];
  logic [DW-1:0] ref_mem [256];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr[7:0]];
  end
  int checks = 0, failures = 0, cnt = 0, dn = 0, got = 0, nv = 0, na = 0;
  logic e_dg, e_cg, e_we, e_dv, e_ca, e_cread, a_read;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd, e_rd, a_rd, old;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    {e_dg, e_cg, e_we, e_dv, e_ca, e_cread, a_read} = '0;
    e_addr = '0; e_wd = '0; e_rd = '0; a_rd = '0; cnt = 0;
  endtask

  // pd/pc/ps < 0 leave that input to the caller; otherwise percent chances
  task automatic cycle(int pd, int pc, int ps);
    logic cw, dw;
    if (pd >= 0 && (e_dg || !bus.disp_req)) begin
      bus.disp_req  = $urandom_range(99) < pd;
      bus.disp_addr = AW'($urandom);
    end
    if (pc >= 0 && (e_cg || !bus.cpu_req)) begin
      bus.cpu_req   = $urandom_range(99) < pc;
      bus.cpu_we    = 1'($urandom_range(1));
      bus.cpu_addr  = AW'($urandom);
      bus.cpu_wdata = DW'($urandom);
    end
    if (ps >= 0) bus.scan = $urandom_range(99) < ps;
    cw = !(e_dg || e_cg) && bus.cpu_req && (!bus.disp_req || cnt == SL || !bus.scan);
    dw = !(e_dg || e_cg) && bus.disp_req && !cw;
    cnt = cw ? 0 : (dw && bus.cpu_req && cnt < SL) ? cnt + 1 : cnt;
    e_dv = e_dg; e_ca = e_cg; e_rd = a_rd; e_cread = a_read;
    e_dg = dw; e_cg = cw; e_we = cw && bus.cpu_we;
    if (cw || dw) begin
      e_addr = cw ? bus.cpu_addr : bus.disp_addr;
      a_rd   = ref_mem[e_addr[7:0]];
      a_read = cw && !bus.cpu_we;
      if (e_we) begin
        e_wd = bus.cpu_wdata;
        ref_mem[e_addr[7:0]] = e_wd;
      end
    end
    @(negedge clk);
    chk("disp_gnt", bus.disp_gnt, e_dg);
    chk("cpu_gnt", bus.cpu_gnt, e_cg);
    chk("mem_we", bus.mem_we, e_we);
    chk("mem_addr", bus.mem_addr, e_addr);
    if (e_we) chk("mem_wdata", bus.mem_wdata, e_wd);
    chk("disp_valid", bus.disp_valid, e_dv);
    chk("cpu_ack", bus.cpu_ack, e_ca);
    if (e_dv) chk("disp_data", bus.disp_data, e_rd);
    if (e_ca && e_cread) chk("cpu_rdata", bus.cpu_rdata, e_rd);
  endtask

  initial begin
    bus.scan = 1'b1; bus.disp_req = 1'b0; bus.disp_addr = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      ram[i] = DW'(i * 7 + 3);
      ref_mem[i] = DW'(i * 7 + 3);
    end
    reset_model();
    #2 rst = 1'b0;
    #1;
    chk("rst_disp_gnt", bus.disp_gnt, 0);
    chk("rst_disp_valid", bus.disp_valid, 0);
    chk("rst_cpu_gnt", bus.cpu_gnt, 0);
    chk("rst_cpu_ack", bus.cpu_ack, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    // display only, incrementing addresses
    bus.disp_req = 1'b1; bus.disp_addr = '0;
    for (int i = 0; i < 7; i++) begin
      cycle(-1, -1, -1);
      if (e_dg) bus.disp_addr = bus.disp_addr + 1'b1;
    end
    bus.disp_req = 1'b0;
    repeat (2) cycle(-1, -1, -1);
    // CPU write then read back
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h1234; bus.cpu_wdata = 8'hA5;
    cycle(-1, -1, -1);
    bus.cpu_req = 1'b0;
    repeat (2) cycle(-1, -1, -1);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0;
    cycle(-1, -1, -1);
    bus.cpu_req = 1'b0;
    cycle(-1, -1, -1);
    chk("rd_a5", bus.cpu_rdata, 8'hA5);
    cycle(-1, -1, -1);
    // starvation: display wins SL slots, then CPU; twice to show the counter cleared
    bus.scan = 1'b1; bus.disp_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0042;
    for (int r = 0; r < 2; r++) begin
      bus.cpu_req = 1'b1; dn = 0; got = 0;
      for (int i = 0; i < 60 && got == 0; i++) begin
        cycle(-1, -1, -1);
        if (bus.disp_gnt) begin dn++; bus.disp_addr = bus.disp_addr + 1'b1; end
        if (bus.cpu_gnt) begin got = 1; bus.cpu_req = 1'b0; end
      end
      chk("starve_disp_wins", dn, SL);
      chk("starve_cpu_won", got, 1);
    end
    bus.disp_req = 1'b0;
    repeat (3) cycle(-1, -1, -1);
    // blanking: CPU takes the first slot
    bus.scan = 1'b0; bus.disp_req = 1'b1; bus.cpu_req = 1'b1;
    cycle(-1, -1, -1);
    chk("scan0_cpu_first", bus.cpu_gnt, 1);
    bus.cpu_req = 1'b0;
    repeat (2) cycle(-1, -1, -1);
    bus.disp_req = 1'b0;
    repeat (2) cycle(-1, -1, -1);
    // alternating scan with both always requesting
    bus.disp_req = 1'b1; bus.cpu_req = 1'b1; dn = 0;
    for (int i = 0; i < 40; i++) begin
      bus.scan = 1'((i / 3) % 2);
      cycle(-1, -1, -1);
      if (bus.disp_gnt) begin dn++; bus.disp_addr = bus.disp_addr + 1'b1; end
      if (bus.cpu_gnt) bus.cpu_addr = bus.cpu_addr + 1'b1;
    end
    chk("alt_scan_disp_slots", dn >= 5, 1);
    bus.disp_req = 1'b0; bus.cpu_req = 1'b0;
    repeat (3) cycle(-1, -1, -1);
    // reset in the middle of a CPU write
    old = ref_mem[8'h77];
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0077; bus.cpu_wdata = 8'h5A;
    cycle(-1, -1, -1);
    bus.cpu_req = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_mid_we_drop", bus.mem_we, 0);
    chk("rst_mid_gnt_drop", bus.cpu_gnt, 0);
    ref_mem[8'h77] = old;
    reset_model();
    repeat (2) begin
      @(negedge clk);
      chk("rst_mid_no_ack", bus.cpu_ack, 0);
    end
    rst = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0;
    cycle(-1, -1, -1);
    bus.cpu_req = 1'b0;
    cycle(-1, -1, -1);
    chk("post_rst_read", bus.cpu_rdata, old);
    cycle(-1, -1, -1);
    // single display pulse, CPU arrives in its RESP cycle
    bus.scan = 1'b1; bus.disp_req = 1'b1; bus.disp_addr = 16'h0010; nv = 0; na = 0;
    cycle(-1, -1, -1);
    bus.disp_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle(-1, -1, -1);
      nv += int'(bus.disp_valid);
      na += int'(bus.cpu_ack);
      if (e_dv) begin bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010; end
      if (e_cg) bus.cpu_req = 1'b0;
    end
    chk("pulse_valid_count", nv, 1);
    chk("pulse_ack_count", na, 1);
    // random traffic
    for (int i = 0; i < 1500; i++)
      cycle(i < 750 ? 70 : 30, 50, (i % 500) < 250 ? 80 : 20);
    repeat (6) cycle(0, 0, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vmem_arbiter.md
Name: vmem_arbiter

Overview:
Shares the single-port, synchronous-read video memory between the display fetch path and the CPU bus. The display fetch path keeps the pixel FIFO fed and normally has priority. The CPU wins ties during vertical blanking, and also after waiting STARVE_LIMIT display grants. The block sits between the framebuffer RAM and the VGA scanout block, in the 100 MHz system clock domain.

Parameters:
AW, 16, address width of all address ports
DW, 8, data width of all data ports
STARVE_LIMIT, 8, display grants the CPU may lose while pending before it is forced a slot (1..15)

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  asynchronous, active-low reset
scan  in  1  vsync from scanout; low = vertical blanking
disp_req  in  1  display read request (level)
disp_addr  in  AW  display read address, held stable while disp_req is high and not yet granted
disp_gnt  out  1  one-cycle pulse: display address accepted
disp_valid  out  1  one-cycle pulse: disp_data valid
disp_data  out  DW  read data for the display
cpu_req  in  1  CPU access request (level)
cpu_we  in  1  1 = write, 0 = read; held with cpu_req
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_gnt  out  1  one-cycle pulse: CPU access accepted
cpu_ack  out  1  one-cycle pulse: access complete; cpu_rdata valid for reads
cpu_rdata  out  DW  read data for the CPU
mem_addr  out  AW  RAM address (registered)
mem_we  out  1  RAM write enable (registered)
mem_wdata  out  DW  RAM write data (registered)
mem_rdata  in  DW  RAM read data, valid one cycle after address

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to IDLE; owner, mem_addr, mem_we, mem_wdata and starvation counter all go to 0.
  - disp_gnt, disp_valid, cpu_gnt and cpu_ack are 0.
- Reset asserted mid-access: the access is abandoned. No gnt, valid or ack is issued for it, and mem_we drops immediately.
- FSM states:
  - IDLE: arbitrate. If a winner exists, go to ACCESS; else stay in IDLE.
  - ACCESS: mem_* hold the winner's access. mem_we = 1 only here, and only for CPU writes. The owner's gnt is high. Always go to RESP.
  - RESP: mem_rdata is valid. Drive the owner's valid/ack, and arbitrate again. If a winner exists, go to ACCESS; else go to IDLE.
- Arbitration in an IDLE or RESP cycle, registered into mem_* at the clock edge. Order:
  - 1. Only one requester asserting: it wins.
  - 2. Both asserting and the starvation counter equals STARVE_LIMIT: CPU wins.
  - 3. Both asserting and scan == 0: CPU wins.
  - 4. Otherwise the display wins.
- Starvation counter (4 bit):
  - Increments on each display win while cpu_req is high.
  - Saturates at STARVE_LIMIT.
  - Clears on a CPU win.
  - Holds when cpu_req is low.
- Latency: a request sampled in cycle N gives gnt in N+1 and valid/ack in N+2.
  - Throughput is one access per 2 cycles when requests are back-to-back.
- Data paths: disp_data = cpu_rdata = mem_rdata (combinational pass-through).
  - Consumers sample only on their own valid/ack.
  - cpu_ack is issued for writes too; cpu_rdata is don't-care on write acks.
- Request protocol:
  - req is a level signal. Each gnt consumes one request.
  - A requester wanting a single access drops req on the edge after seeing gnt.
  - A req still high in the RESP cycle counts as a new request.
  - Address and data are captured at the arbitration edge, so the requester may change them after gnt.
- Non-winner: mem_we = 0 and mem_addr/mem_wdata hold their last values.
- Simultaneous events:
  - A new arbitration in RESP does not suppress the current owner's valid/ack.
  - The owner of RESP may win again in the same cycle.

Test Plan:
- Display only, disp_req held high, addresses 0x0000,0x0001,…: gnt on cycles 1,3,5. disp_valid on cycles 2,4,6. Data equals RAM contents, with 2 cycles per byte.
- CPU write 0xA5 to 0x1234, then read 0x1234 with display idle: mem_we high for exactly 1 cycle. Ack 2 cycles after each request. Read returns 0xA5.
- Both requesting with scan=1 and STARVE_LIMIT=8: display wins 8 consecutive slots, CPU wins the 9th, then the counter is 0.
- Both requesting with scan=0: CPU wins the first slot.
- Both requesting with alternating scan: verify no display starvation.
- rst pulsed low during ACCESS of a CPU write: mem_we drops asynchronously and no cpu_ack appears. FSM is in IDLE, and the next request completes normally.
- disp_req is a single pulse and cpu_req arrives in its RESP cycle: disp_valid and cpu_gnt sequence correctly with no lost or duplicated ack.
